// File: rtl/ahb_mtx_l1_in_stage.sv
//------------------------------------------------------------------------------
// Module   : ahb_mtx_l1_in_stage
// Brief    : Layer-1 AHB matrix input stage. Holds a master address phase that
//            targets an inactive output stage and replays it to the decoder.
// Option   : AHB_MTX_L1_SEQ_CONVERT_EN - replay held SEQ transfers as NONSEQ
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_mtx_l1_in_stage #(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSELS,
  input  logic [AW-1:0] HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic [2:0]    HBURSTS,
  input  logic [3:0]    HPROTS,
  input  logic          HMASTLOCKS,
  input  logic          HREADYS,
  input  logic          active_dec,
  input  logic          readyout_dec,
  input  logic [1:0]    resp_dec,
  output logic          HREADYOUTS,
  output logic [1:0]    HRESPS,
  output logic          sel_op,
  output logic [AW-1:0] addr_op,
  output logic [1:0]    trans_op,
  output logic          write_op,
  output logic [2:0]    size_op,
  output logic [2:0]    burst_op,
  output logic [3:0]    prot_op,
  output logic          mastlock_op,
  output logic          ready_op,
  output logic          held_tran_op
);

  logic          r_held_tran;
  logic          r_sel;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_trans;
  logic          r_write;
  logic [2:0]    r_size;
  logic [2:0]    r_burst;
  logic [3:0]    r_prot;
  logic          r_mastlock;

  logic          w_load;
  logic          w_hold_set;
  logic          w_hold_clr;
  logic [1:0]    w_trans_held;

  // The held flag gates the load, so a new phase never overwrites a pending one.
  assign w_load     = HREADYS & ~r_held_tran & HSELS;
  assign w_hold_set = w_load & HTRANSS[1] & ~active_dec;
  assign w_hold_clr = r_held_tran & active_dec & readyout_dec;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_held_tran <= 1'b0;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_trans     <= 2'b00;
      r_write     <= 1'b0;
      r_size      <= 3'b000;
      r_burst     <= 3'b000;
      r_prot      <= 4'b0000;
      r_mastlock  <= 1'b0;
    end else begin
      if (w_load) begin
        r_sel      <= HSELS;
        r_addr     <= HADDRS;
        r_trans    <= HTRANSS;
        r_write    <= HWRITES;
        r_size     <= HSIZES;
        r_burst    <= HBURSTS;
        r_prot     <= HPROTS;
        r_mastlock <= HMASTLOCKS;
      end
      if (w_hold_set)
        r_held_tran <= 1'b1;
      else if (w_hold_clr)
        r_held_tran <= 1'b0;
    end
  end

`ifdef AHB_MTX_L1_SEQ_CONVERT_EN
  // Arbitration may have broken the burst, so a replayed SEQ restarts as NONSEQ.
  assign w_trans_held = (r_trans == 2'b11) ? 2'b10 : r_trans;
`else
  assign w_trans_held = r_trans;
`endif

  assign sel_op       = r_held_tran ? r_sel        : HSELS;
  assign addr_op      = r_held_tran ? r_addr       : HADDRS;
  assign trans_op     = r_held_tran ? w_trans_held : HTRANSS;
  assign write_op     = r_held_tran ? r_write      : HWRITES;
  assign size_op      = r_held_tran ? r_size       : HSIZES;
  assign burst_op     = r_held_tran ? r_burst      : HBURSTS;
  assign prot_op      = r_held_tran ? r_prot       : HPROTS;
  assign mastlock_op  = r_held_tran ? r_mastlock   : HMASTLOCKS;

  assign ready_op     = r_held_tran ? readyout_dec : HREADYS;
  assign HREADYOUTS   = r_held_tran ? 1'b0         : readyout_dec;
  assign HRESPS       = r_held_tran ? 2'b00        : resp_dec;
  assign held_tran_op = r_held_tran;

endmodule

`default_nettype wire
